// File: rtl/layer_mem_arbiter.sv
// -----------------------------------------------------------------------------
// layer_mem_arbiter
//
// Shares the single layer-memory port among NREQ requesters. The requesters
// are typically the conv write-back engine, the max-pool engine and a host
// readback port. At most one memory command is issued per cycle. Read data
// is returned to the requester that issued the read, at a fixed latency.
// A requester may lock the port for a burst. The lock is released after
// LOCK_MAX consecutive grants, so a locked engine cannot starve the others.
//
// Handshake: a requester drives req[i] together with we/addr/wdata/sel and
// keeps them stable until gnt[i]=1 in the same cycle. The command transfers
// on that rising edge. A requester may drop req without a grant, and nothing
// is then issued for it.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req/we/lock       per-requester request, write flag, burst lock
//   addr/wdata/sel    flattened per-requester fields (requester i at [i*W +: W])
//   gnt               one-hot combinational grant
//   rvalid/rdata      registered read return (one-hot valid, shared data)
//   crd/cwr           registered memory read/write strobes
//   caddr_rd/caddr_wr registered memory read/write addresses
//   cdata_wr/csel     registered memory write data and select
//   cdata_rd          memory read data, valid RD_LAT cycles after crd
//
// Timing: a grant in cycle t drives the memory outputs in cycle t+1.
// cdata_rd is sampled in cycle t+1+RD_LAT. rvalid is high in cycle t+2+RD_LAT.
// -----------------------------------------------------------------------------
module layer_mem_arbiter #(
   parameter int NREQ     = 3,
   parameter int AW       = 12,
   parameter int DW       = 20,
   parameter int SW       = 3,
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    we,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] addr,
   input  logic [NREQ*DW-1:0] wdata,
   input  logic [NREQ*SW-1:0] sel,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output logic [DW-1:0]      rdata,
   output logic               crd,
   output logic               cwr,
   output logic [AW-1:0]      caddr_rd,
   output logic [AW-1:0]      caddr_wr,
   output logic [DW-1:0]      cdata_wr,
   output logic [SW-1:0]      csel,
   input  logic [DW-1:0]      cdata_rd
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(LOCK_MAX + 1);

   localparam logic [0:0] ST_ARB    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [CW-1:0] lock_cnt;

   logic          gnt_any;
   logic [PW-1:0] gnt_idx;
   logic [PW:0]   cand;
   logic [PW-1:0] next_ptr;

   // Unpacked views of the flattened request fields.
   logic [AW-1:0] addr_a  [NREQ];
   logic [DW-1:0] wdata_a [NREQ];
   logic [SW-1:0] sel_a   [NREQ];

   // Read-tag pipeline: stage k is valid in cycle t+1+k for a read granted in
   // cycle t. The last stage lines up with the cycle in which cdata_rd is valid.
   logic [RD_LAT:0] tag_v;
   logic [PW-1:0]   tag_id [RD_LAT+1];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i]  = addr[i*AW +: AW];
         wdata_a[i] = wdata[i*DW +: DW];
         sel_a[i]   = sel[i*SW +: SW];
      end
   end

   // Grant selection. In ARB the scan runs from the highest offset down to
   // offset 0, so the requester closest to the pointer wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      if (state == ST_LOCKED) begin
         gnt_any = req[owner];
         gnt_idx = owner;
      end else begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (req[cand[PW-1:0]]) begin
               gnt_any = 1'b1;
               gnt_idx = cand[PW-1:0];
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (!reset) gnt[gnt_idx] = gnt_any;
   end

   assign next_ptr = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);

   // Arbitration state. The pointer already moves to owner+1 when the lock is
   // taken, so on release the next arbitration starts past the owner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_ARB;
         ptr      <= '0;
         owner    <= '0;
         lock_cnt <= '0;
      end else begin
         case (state)
            ST_ARB: begin
               if (gnt_any) begin
                  ptr <= next_ptr;
                  if (lock[gnt_idx] && (LOCK_MAX > 1)) begin
                     state    <= ST_LOCKED;
                     owner    <= gnt_idx;
                     lock_cnt <= CW'(1);
                  end
               end
            end
            ST_LOCKED: begin
               // If this grant is number LOCK_MAX, the lock is released.
               if (!lock[owner] || (gnt_any && lock_cnt == CW'(LOCK_MAX - 1))) begin
                  state    <= ST_ARB;
                  lock_cnt <= '0;
               end else if (gnt_any) begin
                  lock_cnt <= lock_cnt + CW'(1);
               end
            end
            default: begin
               state    <= ST_ARB;
               lock_cnt <= '0;
            end
         endcase
      end
   end

   // Memory command issue. All fields return to zero in a cycle with no
   // command, so the memory port is quiet when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crd      <= 1'b0;
         cwr      <= 1'b0;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
         csel     <= '0;
      end else begin
         crd      <= gnt_any && !we[gnt_idx];
         cwr      <= gnt_any && we[gnt_idx];
         caddr_rd <= (gnt_any && !we[gnt_idx]) ? addr_a[gnt_idx] : '0;
         caddr_wr <= (gnt_any && we[gnt_idx]) ? addr_a[gnt_idx] : '0;
         cdata_wr <= (gnt_any && we[gnt_idx]) ? wdata_a[gnt_idx] : '0;
         csel     <= gnt_any ? sel_a[gnt_idx] : '0;
      end
   end

   // Read return. Reset clears the tags, so no rvalid appears for reads that
   // were in flight when reset was asserted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_v  <= '0;
         for (int k = 0; k <= RD_LAT; k++) tag_id[k] <= '0;
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         tag_v[0]  <= gnt_any && !we[gnt_idx];
         tag_id[0] <= gnt_idx;
         for (int k = 1; k <= RD_LAT; k++) begin
            tag_v[k]  <= tag_v[k-1];
            tag_id[k] <= tag_id[k-1];
         end
         rvalid <= '0;
         if (tag_v[RD_LAT]) begin
            rvalid[tag_id[RD_LAT]] <= 1'b1;
            rdata                  <= cdata_rd;
         end
      end
   end

endmodule

// File: doc/layer_mem_arbiter.md
Name: layer_mem_arbiter

Overview:
Round-robin arbiter that shares the single layer-memory port (crd/cwr, caddr_rd/caddr_wr, cdata_wr/cdata_rd, csel) among NREQ requesters. Typical requesters are the convolution write-back engine, the max-pool read/write engine and a host readback port. The arbiter issues at most one memory command per cycle and returns read data to the originating requester with a fixed latency. It supports locked bursts with a bounded hold time, so one engine cannot starve the others.

Parameters:
NREQ, 3, number of requesters (2..4)
AW, 12, memory address width
DW, 20, memory data width
SW, 3, csel width
RD_LAT, 1, cycles from the crd-high cycle to valid cdata_rd (1..4)
LOCK_MAX, 16, maximum consecutive grants to one locked requester before a forced release

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester command request
we  in  NREQ  per-requester: 1=write, 0=read
lock  in  NREQ  per-requester: hold ownership for a burst
addr  in  NREQ*AW  flattened addresses; requester i occupies [i*AW +: AW]
wdata  in  NREQ*DW  flattened write data
sel  in  NREQ*SW  flattened memory select
gnt  out  NREQ  one-hot combinational grant; command accepted this cycle
rvalid  out  NREQ  one-hot, registered; read data valid for requester i
rdata  out  DW  registered read data, shared by all requesters
crd  out  1  memory read strobe, registered
cwr  out  1  memory write strobe, registered
caddr_rd  out  AW  memory read address, registered
caddr_wr  out  AW  memory write address, registered
cdata_wr  out  DW  memory write data, registered
csel  out  SW  memory select, registered
cdata_rd  in  DW  memory read data

Behaviour:
- Reset: gnt=0, rvalid=0, rdata=0, crd=0, cwr=0, caddr_rd=0, caddr_wr=0, cdata_wr=0, csel=0. Priority pointer=0, state=ARB, lock counter=0, read-tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them after reset deasserts.
- Handshake: a requester holds req/we/addr/wdata/sel stable until it sees gnt[i]=1 in the same cycle. The transfer occurs on that clock edge.
- State ARB:
  - Grant goes to the first requester with req=1, searching from the pointer upward with wrap mod NREQ.
  - After a grant to w, pointer = (w+1) mod NREQ.
  - If lock[w]=1 at grant: go to LOCKED with owner=w and lock counter=1.
  - No req: gnt=0.
- State LOCKED:
  - Only the owner can be granted; gnt[owner]=req[owner]. Each owner grant increments the counter.
  - Exit to ARB when lock[owner]=0, or when the counter reaches LOCK_MAX.
  - On exit the pointer is owner+1, so the next arbitration cannot pick the owner first if another requester is waiting.
  - Owner idle cycles (req=0, lock=1) keep LOCKED and do not increment the counter.
- Command issue: grant in cycle t drives memory outputs in cycle t+1.
  - Read: crd=1, caddr_rd=addr, csel=sel, cwr=0.
  - Write: cwr=1, caddr_wr=addr, cdata_wr=wdata, csel=sel, crd=0.
  - Cycle after no grant: crd=cwr=0 and all address/data/csel outputs return to 0.
- Read return:
  - cdata_rd is sampled in cycle t+1+RD_LAT.
  - rdata=sampled value and rvalid[w]=1 for exactly one cycle in t+2+RD_LAT (grant-to-rvalid latency = 2+RD_LAT; 3 at default).
  - A tag pipeline (valid + id) of depth RD_LAT+1 tracks ownership. Back-to-back reads return in order, one per cycle.
  - rdata holds its last value while rvalid=0.
- Ordering: commands reach memory in grant order. A write granted after a read to the same address does not affect that read's data.
- Simultaneous events: lock and req from several requesters in the same ARB cycle are resolved by the pointer alone. A requester dropping req without gnt is legal; nothing is issued for it.
- Widths: no arithmetic on data; data passes through unmodified. Pointer and counter wrap exactly as above.

Test Plan:
- Single read: memory[0x041, csel=1]=0x00ABC; req0 read addr 0x041 sel 1 in cycle 0 -> gnt=001 in cycle 0; crd=1, caddr_rd=0x041, csel=1 in cycle 1; rvalid=001 with rdata=0x00ABC in cycle 3.
- Fairness: req=111 held with lock=000 for 9 cycles -> gnt sequence 001,010,100 repeating; no requester waits more than 2 cycles.
- Write: req2 we=1 addr 0x7FF wdata 0xFFFFF sel 3 -> cwr=1, caddr_wr=0x7FF, cdata_wr=0xFFFFF, csel=3 next cycle; crd=0; no rvalid.
- Lock bound: req1 and lock1 held for 20 cycles, req0 held -> 16 consecutive grants to 1, then one grant to 0, then grants to 1 resume.
- Read/write hazard: mem[0x100]=5; req0 read 0x100 and req1 write 0x100 data 9, both in cycle 0 -> read issued first, rdata=5; a subsequent read returns 9.
- Reset mid-read: assert reset in cycle 2 of a granted read -> all outputs 0; no rvalid after release; the next request is granted normally starting from pointer 0.
